// File: rtl/quire_norm_pkg.sv
// Shared definitions for the quire-to-scale-factor extraction pipeline.
// The width helpers are constant functions. They derive the accumulator,
// scale-factor and leading-zero-count widths from the segment geometry.
package quire_norm_pkg;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

    // Full accumulator width: head bits plus all segments.
    function automatic int calc_tot_w(input int head_w, input int nseg, input int seg_w);
        return head_w + nseg * seg_w;
    endfunction

    // Signed scale factor width. It covers +/- any bit position of the accumulator.
    function automatic int calc_sf_w(input int tot_w);
        return $clog2(tot_w) + 1;
    endfunction

    // Leading-zero count width. It can represent the all-zero count w itself.
    function automatic int calc_lzc_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/acc_lzc.sv
// Parametrised leading-zero counter, built as a log-depth binary tree.
//   in_i   [W-1:0]     vector to scan, MSB first
//   cnt_o  [CNT_W-1:0] number of zeros above the first one (W when all zero)
//   zero_o             in_i is all zero
// Non-power-of-two widths are padded at the LSB end with ones. An all-zero
// input therefore counts to exactly W without a separate correction.
module acc_lzc #(
    parameter int W     = 102,
    parameter int CNT_W = $clog2(W + 1)
) (
    input  logic [W-1:0]     in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    localparam int L = $clog2(W);
    localparam int P = 1 << L;

    logic [P-1:0]     ext;
    logic [CNT_W-1:0] cnt_t [0:L][0:P-1];
    logic             vld_t [0:L][0:P-1];

    generate
        if (P > W) begin : g_pad
            assign ext = {in_i, {(P - W){1'b1}}};
        end else begin : g_nopad
            assign ext = in_i;
        end
    endgenerate

    // Node j at level k covers ext[j*2^k +: 2^k]. A node's count is the
    // count of its high child if that child holds a one. Otherwise it is half
    // the node span plus the count of its low child. A leaf counts 1 when its bit is 0.
    always_comb begin
        for (int k = 0; k <= L; k++) begin
            for (int j = 0; j < P; j++) begin
                cnt_t[k][j] = '0;
                vld_t[k][j] = 1'b0;
            end
        end
        for (int j = 0; j < P; j++) begin
            vld_t[0][j] = ext[j];
            cnt_t[0][j] = CNT_W'(!ext[j]);
        end
        for (int k = 1; k <= L; k++) begin
            for (int j = 0; j < (P >> k); j++) begin
                vld_t[k][j] = vld_t[k-1][2*j+1] | vld_t[k-1][2*j];
                cnt_t[k][j] = vld_t[k-1][2*j+1] ? cnt_t[k-1][2*j+1]
                                                : (CNT_W'(1) << (k - 1)) + cnt_t[k-1][2*j];
            end
        end
    end

    assign cnt_o  = cnt_t[L][0];
    assign zero_o = ~|in_i;

endmodule

// File: rtl/quire_norm_sf_pipe.sv
// Quire accumulator to (sign, scale factor, 1.f mantissa, flags) extraction.
// This is a 3-stage valid/ready pipeline, and all stages advance together on en.
//   S1: sign and magnitude of acc_i, with the rounding mode latched
//   S2: leading-zero count, bit position of the leading one, zero detect
//   S3: normalise, round (truncate / RNE), range-classify, register outputs
// Ports:
//   clk_i, rstn (sync, active low), flush_i (sync clear)
//   in_vld / in_rdy, acc_i [TOT_W-1:0] {head, seg[NSEG-1..0]}, rnd_mode_i
//   out_vld / out_rdy, sign_q, sf_q [SF_W-1:0] signed, mts_q [MTS_W-1:0]
//   ovf, udf (also for zero), nzero, inexact_q
module quire_norm_sf_pipe
    import quire_norm_pkg::*;
#(
    parameter  int SEG_W    = 24,
    parameter  int NSEG     = 4,
    parameter  int HEAD_W   = 6,
    parameter  int FRAC_POS = 48,
    parameter  int MTS_W    = 8,
    parameter  int SF_MAX   = 23,
    parameter  int SF_MIN   = -24,
    localparam int TOT_W    = calc_tot_w(HEAD_W, NSEG, SEG_W),
    localparam int SF_W     = calc_sf_w(TOT_W)
) (
    input  logic                    clk_i,
    input  logic                    rstn,
    input  logic                    flush_i,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [TOT_W-1:0]        acc_i,
    input  logic                    rnd_mode_i,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic                    sign_q,
    output logic signed [SF_W-1:0]  sf_q,
    output logic [MTS_W-1:0]        mts_q,
    output logic                    ovf,
    output logic                    udf,
    output logic                    nzero,
    output logic                    inexact_q
);

    localparam int LZC_W = calc_lzc_w(TOT_W);
    localparam int POS_W = $clog2(TOT_W);
    // Two extra bits keep pos - FRAC_POS + carry free of wrap-around before
    // the range compare.
    localparam int SFX_W = SF_W + 2;
    localparam logic signed [SFX_W-1:0] SF_MAX_X = SFX_W'(SF_MAX);
    localparam logic signed [SFX_W-1:0] SF_MIN_X = SFX_W'(SF_MIN);

    logic en;
    assign en     = !out_vld || out_rdy;
    assign in_rdy = en;

    // ---------------- S1: sign / magnitude ----------------
    logic             s1_vld_q,  s1_vld_d;
    logic             s1_sign_q, s1_sign_d;
    logic [TOT_W-1:0] s1_mag_q,  s1_mag_d;
    logic             s1_mode_q, s1_mode_d;

    always_comb begin
        s1_vld_d  = in_vld;
        s1_sign_d = s1_sign_q;
        s1_mag_d  = s1_mag_q;
        s1_mode_d = s1_mode_q;
        if (in_vld) begin
            s1_sign_d = acc_i[TOT_W-1];
            s1_mag_d  = acc_i[TOT_W-1] ? (~acc_i + TOT_W'(1)) : acc_i;
            s1_mode_d = rnd_mode_i;
        end
    end

    // ---------------- S2: leading-zero count ----------------
    logic [LZC_W-1:0] lz_w;
    logic             zero_w;

    acc_lzc #(
        .W     (TOT_W),
        .CNT_W (LZC_W)
    ) u_lzc (
        .in_i   (s1_mag_q),
        .cnt_o  (lz_w),
        .zero_o (zero_w)
    );

    logic             s2_vld_q,  s2_vld_d;
    logic             s2_sign_q, s2_sign_d;
    logic [TOT_W-1:0] s2_mag_q,  s2_mag_d;
    logic             s2_mode_q, s2_mode_d;
    logic [LZC_W-1:0] s2_lz_q,   s2_lz_d;
    logic [POS_W-1:0] s2_pos_q,  s2_pos_d;
    logic             s2_zero_q, s2_zero_d;

    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_sign_d = s2_sign_q;
        s2_mag_d  = s2_mag_q;
        s2_mode_d = s2_mode_q;
        s2_lz_d   = s2_lz_q;
        s2_pos_d  = s2_pos_q;
        s2_zero_d = s2_zero_q;
        if (s1_vld_q) begin
            s2_sign_d = s1_sign_q;
            s2_mag_d  = s1_mag_q;
            s2_mode_d = s1_mode_q;
            s2_lz_d   = lz_w;
            s2_zero_d = zero_w;
            // For zero the position is meaningless and is parked at 0.
            s2_pos_d  = zero_w ? '0 : POS_W'(TOT_W - 1) - POS_W'(lz_w);
        end
    end

    // ---------------- S3: normalise / round / classify ----------------
    logic [TOT_W-1:0]        norm;
    logic [MTS_W-1:0]        m_raw;
    logic                    g_bit;
    logic                    s_bit;
    logic                    rnd_inc;
    logic [MTS_W:0]          m_inc;
    logic                    carry;
    logic [MTS_W-1:0]        mts_rnd;
    logic signed [SFX_W-1:0] sf_x;

    always_comb begin
        norm    = s2_mag_q << s2_lz_q;
        m_raw   = norm[TOT_W-1 -: MTS_W];
        g_bit   = norm[TOT_W-1-MTS_W];
        s_bit   = |norm[TOT_W-2-MTS_W:0];
        rnd_inc = (s2_mode_q == RND_RNE) && g_bit && (s_bit || m_raw[0]);
        m_inc   = {1'b0, m_raw} + (MTS_W + 1)'(rnd_inc);
        carry   = m_inc[MTS_W];
        // A carry out of the mantissa can only come from all ones, so the
        // result is exactly 1.000... one binade up.
        mts_rnd = carry ? {1'b1, {(MTS_W - 1){1'b0}}} : m_inc[MTS_W-1:0];
        sf_x    = $signed(SFX_W'(s2_pos_q)) - $signed(SFX_W'(FRAC_POS))
                + $signed(SFX_W'(carry));
    end

    logic                   out_vld_d;
    logic                   sign_d;
    logic signed [SF_W-1:0] sf_d;
    logic [MTS_W-1:0]       mts_d;
    logic                   ovf_d;
    logic                   udf_d;
    logic                   nzero_d;
    logic                   inexact_d;

    always_comb begin
        out_vld_d = s2_vld_q;
        sign_d    = sign_q;
        sf_d      = sf_q;
        mts_d     = mts_q;
        ovf_d     = ovf;
        udf_d     = udf;
        nzero_d   = nzero;
        inexact_d = inexact_q;
        if (s2_vld_q) begin
            if (s2_zero_q) begin
                sign_d    = 1'b0;
                sf_d      = '0;
                mts_d     = '0;
                ovf_d     = 1'b0;
                udf_d     = 1'b1;
                nzero_d   = 1'b0;
                inexact_d = 1'b0;
            end else begin
                sign_d    = s2_sign_q;
                nzero_d   = 1'b1;
                inexact_d = g_bit | s_bit;
                if (sf_x > SF_MAX_X) begin
                    sf_d  = '0;
                    mts_d = '0;
                    ovf_d = 1'b1;
                    udf_d = 1'b0;
                end else if (sf_x < SF_MIN_X) begin
                    sf_d  = '0;
                    mts_d = '0;
                    ovf_d = 1'b0;
                    udf_d = 1'b1;
                end else begin
                    sf_d  = sf_x[SF_W-1:0];
                    mts_d = mts_rnd;
                    ovf_d = 1'b0;
                    udf_d = 1'b0;
                end
            end
        end
    end

    // Reset and flush clear to identical values. Reset takes precedence only
    // nominally, since both load the same contents.
    always_ff @(posedge clk_i) begin
        if (!rstn || flush_i) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s1_mode_q <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_mag_q  <= '0;
            s2_mode_q <= 1'b0;
            s2_lz_q   <= '0;
            s2_pos_q  <= '0;
            s2_zero_q <= 1'b0;
            out_vld   <= 1'b0;
            sign_q    <= 1'b0;
            sf_q      <= '0;
            mts_q     <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            nzero     <= 1'b1;
            inexact_q <= 1'b0;
        end else if (en) begin
            s1_vld_q  <= s1_vld_d;
            s1_sign_q <= s1_sign_d;
            s1_mag_q  <= s1_mag_d;
            s1_mode_q <= s1_mode_d;
            s2_vld_q  <= s2_vld_d;
            s2_sign_q <= s2_sign_d;
            s2_mag_q  <= s2_mag_d;
            s2_mode_q <= s2_mode_d;
            s2_lz_q   <= s2_lz_d;
            s2_pos_q  <= s2_pos_d;
            s2_zero_q <= s2_zero_d;
            out_vld   <= out_vld_d;
            sign_q    <= sign_d;
            sf_q      <= sf_d;
            mts_q     <= mts_d;
            ovf       <= ovf_d;
            udf       <= udf_d;
            nzero     <= nzero_d;
            inexact_q <= inexact_d;
        end
    end

endmodule

// File: tb/tb_quire_norm_sf_pipe.sv
// Scoreboard bench for quire_norm_sf_pipe at default parameters. The stimulus
// side pushes the expected result on every accepted input. A negedge monitor
// pops and compares on every output transfer.
module tb_quire_norm_sf_pipe;
    import quire_norm_pkg::*;

    localparam int TOT_W = 102;

    logic                clk_i = 1'b0;
    logic                rstn;
    logic                flush_i;
    logic                in_vld;
    logic                in_rdy;
    logic [TOT_W-1:0]    acc_i;
    logic                rnd_mode_i;
    logic                out_vld;
    logic                out_rdy;
    logic                sign_q;
    logic signed [7:0]   sf_q;
    logic [7:0]          mts_q;
    logic                ovf;
    logic                udf;
    logic                nzero;
    logic                inexact_q;

    always #5 clk_i = ~clk_i;

    quire_norm_sf_pipe dut (
        .clk_i      (clk_i),
        .rstn       (rstn),
        .flush_i    (flush_i),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .acc_i      (acc_i),
        .rnd_mode_i (rnd_mode_i),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .sign_q     (sign_q),
        .sf_q       (sf_q),
        .mts_q      (mts_q),
        .ovf        (ovf),
        .udf        (udf),
        .nzero      (nzero),
        .inexact_q  (inexact_q)
    );

    typedef struct packed {
        logic              sign;
        logic signed [31:0] sf;
        logic [7:0]        mts;
        logic              ovf;
        logic              udf;
        logic              nz;
        logic              inex;
    } res_t;

    res_t exp_q[$];
    res_t cur_exp;
    res_t hold_r;
    bit   hold_v   = 1'b0;
    bit   rand_rdy = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;
    int   n_pop    = 0;

    function automatic res_t mk(bit s, int sf, bit [7:0] mts, bit o, bit u, bit nz, bit inex);
        res_t r;
        r.sign = s; r.sf = sf; r.mts = mts; r.ovf = o; r.udf = u; r.nz = nz; r.inex = inex;
        return r;
    endfunction

    // Reference model: value = mag * 2^-48. It finds the leading one, keeps 8
    // bits and rounds the remainder against half an ulp.
    function automatic res_t model(logic [TOT_W-1:0] a, logic mode);
        res_t r;
        logic [TOT_W-1:0] mag;
        logic [127:0] big, mm, rem, half;
        int p, sh;
        bit inc;
        r = '0;
        mag = a[TOT_W-1] ? (TOT_W'(0) - a) : a;
        if (mag == '0) begin
            r.udf = 1'b1;
            return r;
        end
        r.sign = a[TOT_W-1];
        r.nz = 1'b1;
        p = 0;
        for (int i = 0; i < TOT_W; i++) if (mag[i]) p = i;
        big = 128'(mag);
        if (p >= 7) begin
            sh = p - 7;
            mm = big >> sh;
            rem = big - (mm << sh);
        end else begin
            sh = 0;
            mm = big << (7 - p);
            rem = '0;
        end
        r.inex = (rem != 0);
        inc = 1'b0;
        if (mode && sh > 0) begin
            half = 128'(1) << (sh - 1);
            inc = (rem > half) || (rem == half && mm[0]);
        end
        mm = mm + 128'(inc);
        r.sf = p - 48;
        if (mm == 128'd256) begin
            mm = 128'd128;
            r.sf = r.sf + 1;
        end
        if (r.sf > 23) begin
            r.ovf = 1'b1; r.sf = 0; mm = '0;
        end else if (r.sf < -24) begin
            r.udf = 1'b1; r.sf = 0; mm = '0;
        end
        r.mts = mm[7:0];
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.sign = sign_q; r.sf = sf_q; r.mts = mts_q;
        r.ovf = ovf; r.udf = udf; r.nz = nzero; r.inex = inexact_q;
        return r;
    endfunction

    task automatic show(string name, res_t g, res_t e);
        $display("FAIL %s: got sign=%0b sf=%0d mts=%h ovf=%0b udf=%0b nz=%0b inex=%0b, want sign=%0b sf=%0d mts=%h ovf=%0b udf=%0b nz=%0b inex=%0b",
                 name, g.sign, g.sf, g.mts, g.ovf, g.udf, g.nz, g.inex,
                 e.sign, e.sf, e.mts, e.ovf, e.udf, e.nz, e.inex);
    endtask

    // Monitor and scoreboard. Values at the negedge are the ones the next
    // posedge transfers.
    always @(negedge clk_i) begin
        res_t g, e;
        if (!rstn || flush_i) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            g = dut_res();
            if (hold_v && out_vld) begin
                n_vec++;
                if (g !== hold_r) begin
                    n_err++;
                    show("stall-hold", g, hold_r);
                end
            end
            if (out_vld && out_rdy) begin
                n_vec++;
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected-output: got an output with no pending input (sf=%0d mts=%h), want none", g.sf, g.mts);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        n_err++;
                        show("result", g, e);
                    end
                end
            end
            hold_v = out_vld && !out_rdy;
            hold_r = g;
            if (in_vld && in_rdy) exp_q.push_back(cur_exp);
        end
    end

    task automatic chk(string name, longint act, longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(string name);
        chk({name, " out_vld"}, out_vld, 0);
        chk({name, " nzero"},   nzero, 1);
        chk({name, " sign"},    sign_q, 0);
        chk({name, " sf"},      sf_q, 0);
        chk({name, " mts"},     mts_q, 0);
        chk({name, " ovf/udf/inex"}, {ovf, udf, inexact_q}, 0);
        chk({name, " in_rdy"},  in_rdy, 1);
    endtask

    // Present one input and hold it until accepted. Inputs change 1 time unit
    // after the posedge.
    task automatic drive(input logic [TOT_W-1:0] a, input logic m, input res_t e, output int waited);
        bit ok;
        acc_i = a; rnd_mode_i = m; cur_exp = e; in_vld = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk_i);
            ok = in_rdy;
            @(posedge clk_i); #1;
            if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
            if (ok) break;
            waited++;
            if (waited > 200) begin
                n_err++;
                $display("FAIL accept-timeout: got no accept in %0d cycles, want accept", waited);
                break;
            end
        end
        in_vld = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        out_rdy = 1'b1;
        while ((exp_q.size() != 0 || out_vld) && t < 100) begin
            @(posedge clk_i); #1;
            t++;
        end
        chk("drain pending", exp_q.size(), 0);
    endtask

    function automatic logic [TOT_W-1:0] rnd_acc();
        logic [TOT_W-1:0] v, one;
        int k, p;
        k = $urandom_range(0, 9);
        one = TOT_W'(1);
        v = TOT_W'({$urandom, $urandom, $urandom, $urandom});
        if (k == 0) return '0;
        if (k == 1) return one << (TOT_W - 1);
        p = (k < 7) ? $urandom_range(18, 78) : $urandom_range(0, 100);
        v = (v & ((one << p) - one)) | (one << p);
        if (k == 2 && p > 8) v = v & ~((one << (p - 8)) - one);
        if ($urandom_range(0, 1) == 1) v = TOT_W'(0) - v;
        return v;
    endfunction

    initial begin
        logic [TOT_W-1:0] d_acc [15];
        logic             d_md  [15];
        res_t             d_exp [15];
        logic [TOT_W-1:0] one, a;
        logic             m;
        int w, k, base;

        one = TOT_W'(1);
        rstn = 1'b0; flush_i = 1'b0; in_vld = 1'b0; acc_i = '0; rnd_mode_i = 1'b0;
        out_rdy = 1'b1; cur_exp = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_idle("reset");
        rstn = 1'b1;
        @(posedge clk_i); #1;

        // The output becomes valid after the second edge past the accept edge,
        // so the edge that consumes it is accept + 3.
        drive(one << 48, RND_RNE, mk(0, 0, 8'h80, 0, 0, 1, 0), w);
        k = 0;
        while (k < 10) begin
            @(negedge clk_i);
            if (out_vld) break;
            @(posedge clk_i); #1;
            k++;
        end
        chk("latency", k + 1, 3);
        drain();

        d_acc[0]  = one << 48;                    d_md[0]  = RND_RNE;   d_exp[0]  = mk(0, 0,   8'h80, 0, 0, 1, 0);
        d_acc[1]  = TOT_W'(0) - (TOT_W'(3) << 47); d_md[1]  = RND_RNE;   d_exp[1]  = mk(1, 0,   8'hC0, 0, 0, 1, 0);
        d_acc[2]  = TOT_W'(9'h1FF) << 40;         d_md[2]  = RND_RNE;   d_exp[2]  = mk(0, 1,   8'h80, 0, 0, 1, 1);
        d_acc[3]  = TOT_W'(9'h1FF) << 40;         d_md[3]  = RND_TRUNC; d_exp[3]  = mk(0, 0,   8'hFF, 0, 0, 1, 1);
        d_acc[4]  = one << 71;                    d_md[4]  = RND_TRUNC; d_exp[4]  = mk(0, 23,  8'h80, 0, 0, 1, 0);
        d_acc[5]  = one << 72;                    d_md[5]  = RND_RNE;   d_exp[5]  = mk(0, 0,   8'h00, 1, 0, 1, 0);
        d_acc[6]  = one << 24;                    d_md[6]  = RND_RNE;   d_exp[6]  = mk(0, -24, 8'h80, 0, 0, 1, 0);
        d_acc[7]  = one << 23;                    d_md[7]  = RND_RNE;   d_exp[7]  = mk(0, 0,   8'h00, 0, 1, 1, 0);
        d_acc[8]  = '0;                           d_md[8]  = RND_RNE;   d_exp[8]  = mk(0, 0,   8'h00, 0, 1, 0, 0);
        d_acc[9]  = one << 101;                   d_md[9]  = RND_RNE;   d_exp[9]  = mk(1, 0,   8'h00, 1, 0, 1, 0);
        d_acc[10] = '1;                           d_md[10] = RND_RNE;   d_exp[10] = mk(1, 0,   8'h00, 0, 1, 1, 0);
        d_acc[11] = TOT_W'(9'h101) << 40;         d_md[11] = RND_RNE;   d_exp[11] = mk(0, 0,   8'h80, 0, 0, 1, 1);
        d_acc[12] = TOT_W'(9'h103) << 40;         d_md[12] = RND_RNE;   d_exp[12] = mk(0, 0,   8'h82, 0, 0, 1, 1);
        d_acc[13] = TOT_W'(9'h1FF) << 63;         d_md[13] = RND_RNE;   d_exp[13] = mk(0, 0,   8'h00, 1, 0, 1, 1);
        d_acc[14] = TOT_W'(9'h1FF) << 63;         d_md[14] = RND_TRUNC; d_exp[14] = mk(0, 23,  8'hFF, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) drive(d_acc[i], d_md[i], d_exp[i], w);
        drain();

        // Backpressure: three inputs fill the pipe, then in_rdy must stay low.
        base = n_pop;
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rnd_acc(); m = 1'($urandom_range(0, 1));
            drive(a, m, model(a, m), w);
            chk("bp no-wait accept", w, 0);
        end
        a = rnd_acc(); m = 1'($urandom_range(0, 1));
        cur_exp = model(a, m); acc_i = a; rnd_mode_i = m; in_vld = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            chk("bp in_rdy low", in_rdy, 0);
            @(posedge clk_i); #1;
        end
        out_rdy = 1'b1;
        drive(a, m, model(a, m), w);
        a = rnd_acc(); m = 1'($urandom_range(0, 1));
        drive(a, m, model(a, m), w);
        drain();
        chk("bp result count", n_pop - base, 5);

        // Flush mid-stream, with an input being offered in the same cycle.
        for (int i = 0; i < 2; i++) begin
            a = rnd_acc(); drive(a, RND_RNE, model(a, RND_RNE), w);
        end
        a = rnd_acc(); cur_exp = model(a, 1'b0); acc_i = a; rnd_mode_i = 1'b0; in_vld = 1'b1;
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; in_vld = 1'b0;
        chk_idle("flush");
        drive(TOT_W'(0) - (TOT_W'(3) << 47), RND_RNE, mk(1, 0, 8'hC0, 0, 0, 1, 0), w);
        drain();

        // Reset mid-stream.
        for (int i = 0; i < 2; i++) begin
            a = rnd_acc(); drive(a, RND_TRUNC, model(a, RND_TRUNC), w);
        end
        rstn = 1'b0;
        @(posedge clk_i); #1;
        rstn = 1'b1;
        chk_idle("mid reset");
        drive(one << 71, RND_RNE, mk(0, 23, 8'h80, 0, 0, 1, 0), w);
        drain();

        // Random traffic with random downstream stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = rnd_acc(); m = 1'($urandom_range(0, 1));
            drive(a, m, model(a, m), w);
        end
        rand_rdy = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
